// File: rtl/tmr_mon_pkg.sv
// rtl/tmr_mon_pkg.sv - shared types and lane/select constants for the TMR vote monitor
package tmr_mon_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SNAP = 2'd1,
        ACK  = 2'd2
    } rd_state_t;

    localparam logic [1:0] LANE_A    = 2'd0;
    localparam logic [1:0] LANE_B    = 2'd1;
    localparam logic [1:0] LANE_C    = 2'd2;
    localparam logic [1:0] SEL_MULTI = 2'd3;

endpackage

// File: rtl/tmr_lane_checker.sv
// rtl/tmr_lane_checker.sv - per-lane mismatch pulse, run-length, sticky fault and error counter
module tmr_lane_checker
    import tmr_mon_pkg::*;
#(
    parameter int WIDTH   = 8,
    parameter int CNT_W   = 16,
    parameter int PERSIST = 3
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic [WIDTH-1:0] i_in,
    input  logic [WIDTH-1:0] i_vote,
    input  logic             i_multi,
    input  logic             i_fault_clr,
    input  logic             i_cnt_clr,
    output logic             o_err,
    output logic             o_fault,
    output logic [CNT_W-1:0] o_cnt
);

    localparam int RL_W = $clog2(PERSIST + 1);
    localparam logic [RL_W-1:0] RL_MAX = RL_W'(PERSIST);

    logic             w_mis;
    logic             w_hit;
    logic [RL_W-1:0]  w_run_inc;
    logic             r_err;
    logic             r_fault;
    logic [RL_W-1:0]  r_run;
    logic [CNT_W-1:0] r_cnt;

    // A lane mismatch only counts when the vote is meaningful (not a multi-error cycle)
    assign w_mis     = (i_in != i_vote);
    assign w_hit     = w_mis && !i_multi;
    assign w_run_inc = (r_run == RL_MAX) ? RL_MAX : r_run + 1'b1;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_err   <= 1'b0;
            r_fault <= 1'b0;
            r_run   <= '0;
            r_cnt   <= '0;
        end else begin
            r_err <= w_hit;

            if (i_fault_clr) begin
                r_fault <= 1'b0;
                r_run   <= w_hit ? RL_W'(1) : '0;
            end else if (!i_multi) begin
                if (w_mis) begin
                    r_run <= w_run_inc;
                    if (w_run_inc == RL_MAX) begin
                        r_fault <= 1'b1;
                    end
                end else begin
                    r_run <= '0;
                end
            end

            // Clearing read keeps a same-cycle event so nothing is lost
            if (i_cnt_clr) begin
                r_cnt <= w_hit ? CNT_W'(1) : '0;
            end else if (w_hit && (r_cnt != '1)) begin
                r_cnt <= r_cnt + 1'b1;
            end
        end
    end

    assign o_err   = r_err;
    assign o_fault = r_fault;
    assign o_cnt   = r_cnt;

endmodule

// File: rtl/tmr_vote_monitor.sv
// rtl/tmr_vote_monitor.sv - registered TMR majority vote with lane monitoring and counter readout
module tmr_vote_monitor
    import tmr_mon_pkg::*;
#(
    parameter int WIDTH   = 8,
    parameter int CNT_W   = 16,
    parameter int PERSIST = 3
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic [WIDTH-1:0] inA,
    input  logic [WIDTH-1:0] inB,
    input  logic [WIDTH-1:0] inC,
    output logic [WIDTH-1:0] out,
    output logic [2:0]       err,
    output logic             multi_err,
    output logic [2:0]       fault,
    input  logic             fault_clr,
    input  logic             rd_req,
    input  logic [1:0]       rd_sel,
    input  logic             rd_clr,
    output logic             rd_ack,
    output logic [CNT_W-1:0] rd_data
);

    logic [WIDTH-1:0] w_vote;
    logic             w_multi;
    logic [WIDTH-1:0] w_lane [3];
    logic [CNT_W-1:0] w_cnt  [3];
    logic [2:0]       w_err;
    logic [2:0]       w_fault;
    logic [CNT_W-1:0] w_sel_cnt;
    logic             w_latch;
    logic             w_snap;
    rd_state_t        w_state_nxt;

    rd_state_t        r_state;
    logic [1:0]       r_sel;
    logic             r_clr;
    logic             r_rd_ack;
    logic [CNT_W-1:0] r_rd_data;
    logic [WIDTH-1:0] r_out;
    logic             r_multi_err;
    logic [CNT_W-1:0] r_cnt_m;

    assign w_vote  = (inA & inB) | (inB & inC) | (inA & inC);
    assign w_multi = (inA != inB) && (inB != inC) && (inA != inC);

    assign w_lane[0] = inA;
    assign w_lane[1] = inB;
    assign w_lane[2] = inC;

    for (genvar g = 0; g < 3; g++) begin : g_lane
        tmr_lane_checker #(
            .WIDTH   (WIDTH),
            .CNT_W   (CNT_W),
            .PERSIST (PERSIST)
        ) u_chk (
            .clk         (clk),
            .rstn        (rstn),
            .i_in        (w_lane[g]),
            .i_vote      (w_vote),
            .i_multi     (w_multi),
            .i_fault_clr (fault_clr),
            .i_cnt_clr   (w_snap && r_clr && (r_sel == 2'(g))),
            .o_err       (w_err[g]),
            .o_fault     (w_fault[g]),
            .o_cnt       (w_cnt[g])
        );
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_out       <= '0;
            r_multi_err <= 1'b0;
            r_cnt_m     <= '0;
        end else begin
            r_out       <= w_vote;
            r_multi_err <= w_multi;
            if (w_snap && r_clr && (r_sel == SEL_MULTI)) begin
                r_cnt_m <= w_multi ? CNT_W'(1) : '0;
            end else if (w_multi && (r_cnt_m != '1)) begin
                r_cnt_m <= r_cnt_m + 1'b1;
            end
        end
    end

    always_comb begin
        w_sel_cnt = r_cnt_m;
        case (r_sel)
            LANE_A:  w_sel_cnt = w_cnt[0];
            LANE_B:  w_sel_cnt = w_cnt[1];
            LANE_C:  w_sel_cnt = w_cnt[2];
            default: w_sel_cnt = r_cnt_m;
        endcase
    end

    always_comb begin
        w_state_nxt = r_state;
        w_latch     = 1'b0;
        w_snap      = 1'b0;
        case (r_state)
            IDLE: begin
                if (rd_req) begin
                    w_state_nxt = SNAP;
                    w_latch     = 1'b1;
                end
            end
            SNAP: begin
                w_state_nxt = ACK;
                w_snap      = 1'b1;
            end
            ACK: begin
                if (!rd_req) begin
                    w_state_nxt = IDLE;
                end
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    // Snapshot taken in SNAP so rd_data holds the pre-clear value for the whole ack
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_state   <= IDLE;
            r_sel     <= LANE_A;
            r_clr     <= 1'b0;
            r_rd_ack  <= 1'b0;
            r_rd_data <= '0;
        end else begin
            r_state  <= w_state_nxt;
            r_rd_ack <= (w_state_nxt == ACK);
            if (w_latch) begin
                r_sel <= rd_sel;
                r_clr <= rd_clr;
            end
            if (w_snap) begin
                r_rd_data <= w_sel_cnt;
            end
        end
    end

    assign out       = r_out;
    assign err       = w_err;
    assign multi_err = r_multi_err;
    assign fault     = w_fault;
    assign rd_ack    = r_rd_ack;
    assign rd_data   = r_rd_data;

endmodule

// File: tb/tb_tmr_vote_monitor.sv
// tb/tb_tmr_vote_monitor.sv - scoreboard bench for tmr_vote_monitor
module tb_tmr_vote_monitor;

    logic       clk = 1'b0;
    logic       rstn = 1'b0;
    logic [7:0] inA = '0, inB = '0, inC = '0;
    logic [7:0] out;
    logic [2:0] err;
    logic       multi_err;
    logic [2:0] fault;
    logic       fault_clr = 1'b0;
    logic       rd_req = 1'b0;
    logic [1:0] rd_sel = '0;
    logic       rd_clr = 1'b0;
    logic       rd_ack;
    logic [3:0] rd_data;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;

    typedef struct {
        int         due;
        logic [7:0] eo;
        logic [2:0] ee;
        logic       em;
        logic [2:0] ef;
    } exp_t;

    exp_t       vq[$];
    logic [3:0] rdq[$];
    logic [2:0] ef_g = '0;
    logic       prev_ack = 1'b0;

    tmr_vote_monitor #(.WIDTH(8), .CNT_W(4), .PERSIST(3)) dut (
        .clk       (clk),
        .rstn      (rstn),
        .inA       (inA),
        .inB       (inB),
        .inC       (inC),
        .out       (out),
        .err       (err),
        .multi_err (multi_err),
        .fault     (fault),
        .fault_clr (fault_clr),
        .rd_req    (rd_req),
        .rd_sel    (rd_sel),
        .rd_clr    (rd_clr),
        .rd_ack    (rd_ack),
        .rd_data   (rd_data)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Drive one vector; the expected registered response is queued for the monitor
    task automatic step(input logic [7:0] a, input logic [7:0] b, input logic [7:0] c,
                        input logic [7:0] eo, input logic [2:0] ee, input logic em);
        exp_t e;
        inA = a;
        inB = b;
        inC = c;
        e.due = cyc + 1;
        e.eo  = eo;
        e.ee  = ee;
        e.em  = em;
        e.ef  = ef_g;
        vq.push_back(e);
        @(posedge clk);
        #2;
    endtask

    task automatic quiet();
        step(8'h5A, 8'h5A, 8'h5A, 8'h5A, 3'b000, 1'b0);
    endtask

    task automatic readout(input logic [1:0] sel, input logic clr, input logic [3:0] exp,
                           input logic snap_a);
        rdq.push_back(exp);
        rd_sel = sel;
        rd_clr = clr;
        rd_req = 1'b1;
        quiet();
        check("rd_ack_lat1", rd_ack, 1'b0);
        rd_clr = 1'b0;
        if (snap_a) step(8'hFF, 8'h5A, 8'h5A, 8'h5A, 3'b001, 1'b0);
        else        quiet();
        check("rd_ack_lat2", rd_ack, 1'b1);
        rd_req = 1'b0;
        quiet();
        check("rd_ack_drop", rd_ack, 1'b0);
    endtask

    always @(negedge clk) begin
        while (vq.size() > 0 && vq[0].due <= cyc) begin
            exp_t e;
            e = vq.pop_front();
            check("out", out, e.eo);
            check("err", err, e.ee);
            check("multi_err", multi_err, e.em);
            check("fault", fault, e.ef);
        end
        if (rd_ack && !prev_ack) begin
            if (rdq.size() == 0) begin
                check("rd_unexpected_ack", rd_ack, 1'b0);
            end else begin
                check("rd_data", rd_data, rdq.pop_front());
            end
        end
        prev_ack <= rd_ack;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        repeat (3) @(posedge clk);
        #2;
        check("rst_out", out, 8'h00);
        check("rst_err", err, 3'b000);
        check("rst_multi", multi_err, 1'b0);
        check("rst_fault", fault, 3'b000);
        check("rst_ack", rd_ack, 1'b0);
        check("rst_data", rd_data, 4'h0);
        rstn = 1'b1;

        repeat (10) quiet();
        step(8'h00, 8'hFF, 8'h00, 8'h00, 3'b010, 1'b0);
        quiet();

        step(8'h5A, 8'h5A, 8'hA5, 8'h5A, 3'b100, 1'b0);
        step(8'h5A, 8'h5A, 8'hA5, 8'h5A, 3'b100, 1'b0);
        ef_g = 3'b100;
        step(8'h5A, 8'h5A, 8'hA5, 8'h5A, 3'b100, 1'b0);
        quiet();
        fault_clr = 1'b1;
        ef_g = 3'b000;
        quiet();
        fault_clr = 1'b0;

        step(8'h01, 8'h02, 8'h04, 8'h00, 3'b000, 1'b1);
        quiet();

        readout(2'd1, 1'b0, 4'd1, 1'b0);
        readout(2'd2, 1'b0, 4'd3, 1'b0);
        readout(2'd3, 1'b0, 4'd1, 1'b0);
        readout(2'd0, 1'b0, 4'd0, 1'b0);

        for (int i = 0; i < 20; i++) begin
            if (i == 2) ef_g = 3'b001;
            step(8'hFF, 8'h5A, 8'h5A, 8'h5A, 3'b001, 1'b0);
        end
        readout(2'd0, 1'b1, 4'd15, 1'b1);
        readout(2'd0, 1'b0, 4'd1, 1'b0);

        rdq.push_back(4'd1);
        rd_sel = 2'd0;
        rd_req = 1'b1;
        quiet();
        quiet();
        check("mid_rd_ack", rd_ack, 1'b1);
        @(negedge clk);
        #1;
        rstn = 1'b0;
        #1;
        check("arst_ack", rd_ack, 1'b0);
        check("arst_out", out, 8'h00);
        check("arst_fault", fault, 3'b000);
        check("arst_data", rd_data, 4'h0);
        rd_req = 1'b0;
        ef_g = 3'b000;
        @(posedge clk);
        #2;
        rstn = 1'b1;

        readout(2'd0, 1'b0, 4'd0, 1'b0);
        readout(2'd3, 1'b0, 4'd0, 1'b0);

        for (int i = 0; i < 20; i++) begin
            if (vq.size() == 0 && rdq.size() == 0) break;
            @(negedge clk);
        end
        check("vq_drained", vq.size(), 0);
        check("rdq_drained", rdq.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
